firdec: RTL and testbench
=========================

FIRDEC -- requirements
Module: firdec

Interface
REQ-001 The block SHALL have parameter IW, default 16, meaning signed input sample width, matching the FIR accumulator output.
REQ-002 The block SHALL have parameter OW, default 8, meaning signed output sample width, with OW <= IW.
REQ-003 The block SHALL have parameter SHIFT, default 4, meaning arithmetic right-shift applied before requantization, with 0 <= SHIFT < IW.
REQ-004 The block SHALL have parameter M, default 4, meaning decimation factor, with M >= 1.
REQ-005 The block SHALL have parameter DEPTH, default 4, meaning output FIFO depth, a power of 2 and >= 2.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port clear, input, 1 bit: reset, synchronous, active-high.
REQ-008 The block SHALL have port valid, input, 1 bit: x carries a new sample this cycle.
REQ-009 The block SHALL have port x, input, IW bits: signed input sample.
REQ-010 The block SHALL have port out_valid, output, 1 bit: FIFO head is available.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts the head this cycle.
REQ-012 The block SHALL have port y, output, OW bits: signed output sample, equal to the FIFO head; 0 when out_valid=0.
REQ-013 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag, set when any kept sample exceeds the OW range after shift.
REQ-015 The block SHALL have port drop, output, 1 bit: one-cycle pulse when a requantized sample is discarded because the FIFO is full.

Function
REQ-016 Decimation counter cnt: range 0..M-1, advances on each valid; wraps M-1 -> 0; the sample arriving with cnt==M-1 is kept and all others are discarded; M=1 keeps every sample.
REQ-017 Stage 1 register: a kept sample SHALL be computed as r = (x + 2^(SHIFT-1)) >>> SHIFT, in IW+1 bits, with round-half-up; when SHIFT=0, r = x and no rounding add is applied.
REQ-018 Range check: if r > 2^(OW-1)-1 or r < -2^(OW-1), overflow SHALL be set, and SHALL hold until clear.
REQ-019 The stage 1 result SHALL be written to the FIFO in the cycle after it is registered; with the FIFO empty, out_valid SHALL rise 2 cycles after the kept valid edge.
REQ-020 A pop SHALL occur when out_valid && out_ready; order is strictly FIFO; out_valid SHALL equal (level != 0).
REQ-021 Write when full without a pop: the sample SHALL be discarded, drop=1 for that cycle, and FIFO contents SHALL be unchanged.
REQ-022 Write and pop in the same cycle when full: the write SHALL be accepted, level SHALL stay DEPTH, and drop SHALL stay 0.
REQ-023 Write and pop in the same cycle when empty is impossible, since the pop requires out_valid; a write to an empty FIFO SHALL become visible on the next cycle.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; level SHALL be exact from 0 to DEPTH.
REQ-025 The block SHALL sustain one input per cycle indefinitely; valid low stalls cnt and produces no writes.

Reset
REQ-026 On clear, the following SHALL go to 0 on the same edge: cnt, stage 1 valid, FIFO pointers, level, out_valid, y, overflow and drop.
REQ-027 A valid asserted in the same cycle as clear SHALL be ignored.
REQ-028 A clear asserted mid-stream SHALL discard in-flight and buffered samples, and the next accepted input SHALL count as cnt=0.

Configuration
REQ-029 With FIRDEC_SAT_EN defined, out-of-range r SHALL clamp to 2^(OW-1)-1 or -2^(OW-1).
REQ-030 Without FIRDEC_SAT_EN, out-of-range r SHALL wrap to its low OW bits; overflow SHALL behave identically in both builds.

Structure
REQ-031 A shared package firdec_pkg SHALL hold the level-width constant function and the saturate/round helper functions.
REQ-032 The FIFO SHALL be a sub-module firdec_fifo, with parameters OW and DEPTH, plus push, pop, full, empty and level; decimation and requantization SHALL stay in firdec.

Verification (IW=16, OW=8, SHIFT=4, M=4, DEPTH=4)
REQ-033 Inputs 16,32,48,64 with valid on consecutive cycles and out_ready=1 -> one output y=4, out_valid high 2 cycles after the 64 is accepted, for 1 cycle.
REQ-034 Kept samples 24, -24, 7 -> y = 2, -1, 0; overflow stays 0.
REQ-035 Kept sample 4000 -> y=127 with SAT_EN or -6 without it, overflow=1; kept -4000 -> y=-128 (SAT_EN).
REQ-036 out_ready=0 with 5 kept samples -> level=4, drop pulses once on the 5th; then out_ready=1 -> the first 4 drain in order.
REQ-037 FIFO full, then a kept sample arrives in the same cycle as a pop -> level stays 4, drop=0, and the new sample is last out.
REQ-038 clear asserted with level=3 and cnt=2 -> the next cycle shows level=0, out_valid=0, overflow=0; the following 4 inputs yield exactly one output, taken from the 4th of them.

Source files
------------

// File: rtl/firdec_pkg.sv
`default_nettype none
// ============================================================================
// Module     : firdec_pkg
// Description: Shared constants and helper functions for the FIR decimator /
//              requantizer. The rounding and saturation helpers work on a
//              wide signed intermediate so that callers with any IW/OW can
//              use them and cast the result down to their own width.
// Revision   : 1.0 - initial release
// ============================================================================
package firdec_pkg;

    // Width of the wide signed intermediate used by the helpers
    localparam int unsigned C_CALC_W = 64;

    // Width of an occupancy counter that must represent 0..depth inclusive
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Round-half-up arithmetic right shift; sh == 0 passes v through untouched
    function automatic logic signed [C_CALC_W-1:0] round_shr(
        input logic signed [C_CALC_W-1:0] v,
        input int                         sh
    );
        logic signed [C_CALC_W-1:0] bias;
        if (sh == 0) begin
            return v;
        end
        bias = 64'sd1 <<< (sh - 1);
        return (v + bias) >>> sh;
    endfunction

    function automatic logic signed [C_CALC_W-1:0] ow_max(input int ow);
        return (64'sd1 <<< (ow - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [C_CALC_W-1:0] ow_min(input int ow);
        return -(64'sd1 <<< (ow - 1));
    endfunction

    // True when v cannot be represented as an ow-bit signed value
    function automatic logic out_of_range(
        input logic signed [C_CALC_W-1:0] v,
        input int                         ow
    );
        return (v > ow_max(ow)) || (v < ow_min(ow));
    endfunction

    // Clamp v into the ow-bit signed range
    function automatic logic signed [C_CALC_W-1:0] sat(
        input logic signed [C_CALC_W-1:0] v,
        input int                         ow
    );
        if (v > ow_max(ow)) begin
            return ow_max(ow);
        end
        if (v < ow_min(ow)) begin
            return ow_min(ow);
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/firdec_fifo.sv
`default_nettype none
// ============================================================================
// Module     : firdec_fifo
// Description: Synchronous output FIFO for the decimator. A push into a full
//              FIFO is only accepted when a pop happens in the same cycle.
//              o_data reads 0 while the FIFO is empty.
// Ports      : clk, rst       - clock, synchronous active-high reset
//              i_push, i_data - write request and data
//              i_pop          - read request (ignored when empty)
//              o_data         - FIFO head
//              o_full/o_empty - occupancy flags
//              o_level        - occupancy 0..DEPTH
// Revision   : 1.0 - initial release
// ============================================================================
module firdec_fifo
    import firdec_pkg::*;
#(
    parameter int OW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [OW-1:0]              i_data,
    input  logic                       i_pop,
    output logic [OW-1:0]              o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [lvl_w(DEPTH)-1:0]    o_level
);

    localparam int C_PW = $clog2(DEPTH);
    localparam int C_LW = lvl_w(DEPTH);

    logic [OW-1:0]   r_mem_q [DEPTH];
    logic [C_PW-1:0] r_rd_q;
    logic [C_PW-1:0] r_wr_q;
    logic [C_LW-1:0] r_level_q;
    logic [C_LW-1:0] w_level_d;
    logic            w_pop_ok;
    logic            w_push_ok;

    assign o_empty   = (r_level_q == '0);
    assign o_full    = (r_level_q == C_LW'(DEPTH));
    assign w_pop_ok  = i_pop && !o_empty;
    // A full FIFO frees a slot in the same cycle it is popped
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_comb begin
        w_level_d = r_level_q;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_level_d = r_level_q + C_LW'(1);
            2'b01:   w_level_d = r_level_q - C_LW'(1);
            default: w_level_d = r_level_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_q    <= '0;
            r_wr_q    <= '0;
            r_level_q <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_q <= r_wr_q + C_PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_q <= r_rd_q + C_PW'(1);
            end
            r_level_q <= w_level_d;
        end
    end

    // Storage needs no reset: the head is masked while empty
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_q[r_wr_q] <= i_data;
        end
    end

    assign o_data  = o_empty ? '0 : r_mem_q[r_rd_q];
    assign o_level = r_level_q;

endmodule
`default_nettype wire

// File: rtl/firdec.sv
`default_nettype none
// ============================================================================
// Module     : firdec
// Description: Keeps every M-th valid input sample, rounds it by an arithmetic
//              right shift of SHIFT bits, requantizes to OW bits and queues
//              the result in a DEPTH-entry output FIFO.
//              Build option FIRDEC_SAT_EN: out-of-range results clamp to the
//              OW range; otherwise they wrap to their low OW bits.
// Ports      : clk, clear      - clock, synchronous active-high reset
//              valid, x        - input sample strobe and data
//              out_valid, y    - FIFO head present / head value (0 if none)
//              out_ready       - consumer takes the head
//              level           - FIFO occupancy
//              overflow        - sticky out-of-range flag
//              drop            - one-cycle pulse when a result hits a full FIFO
// Revision   : 1.0 - initial release
// ============================================================================
module firdec
    import firdec_pkg::*;
#(
    parameter int IW    = 16,
    parameter int OW    = 8,
    parameter int SHIFT = 4,
    parameter int M     = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       valid,
    input  logic signed [IW-1:0]       x,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OW-1:0]       y,
    output logic [lvl_w(DEPTH)-1:0]    level,
    output logic                       overflow,
    output logic                       drop
);

    localparam int C_CW = (M > 1) ? $clog2(M) : 1;

    logic [C_CW-1:0]     r_cnt_q;
    logic [C_CW-1:0]     w_cnt_d;
    logic                w_keep;
    logic signed [IW:0]  w_r;
    logic                w_ovf;
    logic [OW-1:0]       w_req;
    logic                r_s1_vld_q;
    logic [OW-1:0]       r_s1_data_q;
    logic                r_ovf_q;
    logic                r_drop_q;
    logic                w_full;
    logic                w_empty;
    logic [OW-1:0]       w_head;

    // ---------------------------------------------------------------- decimate
    assign w_keep  = valid && (r_cnt_q == C_CW'(M - 1));
    assign w_cnt_d = (r_cnt_q == C_CW'(M - 1)) ? '0 : r_cnt_q + C_CW'(1);

    // ------------------------------------------------------------- requantize
    // IW+1 bits hold the rounded result without loss for any input
    assign w_r   = (IW + 1)'(round_shr(64'(x), SHIFT));
    assign w_ovf = out_of_range(64'(w_r), OW);

`ifdef FIRDEC_SAT_EN
    assign w_req = OW'(sat(64'(w_r), OW));
`else
    assign w_req = OW'(w_r);
`endif

    // ---------------------------------------------------------------- stage 1
    always_ff @(posedge clk) begin
        if (clear) begin
            r_cnt_q     <= '0;
            r_s1_vld_q  <= 1'b0;
            r_s1_data_q <= '0;
            r_ovf_q     <= 1'b0;
            r_drop_q    <= 1'b0;
        end else begin
            if (valid) begin
                r_cnt_q <= w_cnt_d;
            end
            r_s1_vld_q <= w_keep;
            if (w_keep) begin
                r_s1_data_q <= w_req;
                if (w_ovf) begin
                    r_ovf_q <= 1'b1;
                end
            end
            // A stage 1 result that meets a full FIFO with no pop is lost
            r_drop_q <= r_s1_vld_q && w_full && !out_ready;
        end
    end

    // ------------------------------------------------------------ output FIFO
    firdec_fifo #(
        .OW    (OW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (clear),
        .i_push  (r_s1_vld_q),
        .i_data  (r_s1_data_q),
        .i_pop   (out_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign out_valid = !w_empty;
    assign y         = w_head;
    assign overflow  = r_ovf_q;
    assign drop      = r_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_firdec.sv
`default_nettype none
// ============================================================================
// Module     : tb_firdec
// Description: Scoreboard bench for firdec (IW=16, OW=8, SHIFT=4, M=4,
//              DEPTH=4). Stimulus pushes hand-computed outputs into a queue;
//              a negedge monitor pops and compares whenever a pop happens.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_firdec;

    localparam int IW    = 16;
    localparam int OW    = 8;
    localparam int SHIFT = 4;
    localparam int M     = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

`ifdef FIRDEC_SAT_EN
    localparam int EXP_POS_BIG = 127;
    localparam int EXP_NEG_BIG = -128;
`else
    localparam int EXP_POS_BIG = -6;
    localparam int EXP_NEG_BIG = 6;
`endif

    logic                 clk = 1'b0;
    logic                 clear;
    logic                 valid;
    logic signed [IW-1:0] x;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] y;
    logic [LW-1:0]        level;
    logic                 overflow;
    logic                 drop;

    int n_tests  = 0;
    int n_fail   = 0;
    int drop_cnt = 0;
    int out_cnt  = 0;
    logic signed [OW-1:0] sb[$];
    logic signed [OW-1:0] mon_exp;

    firdec #(
        .IW    (IW),
        .OW    (OW),
        .SHIFT (SHIFT),
        .M     (M),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .valid     (valid),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .level     (level),
        .overflow  (overflow),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (drop === 1'b1) begin
            drop_cnt++;
        end
        if (clear === 1'b0) begin
            check("valid_eq_level_nz", longint'(out_valid), longint'(level != '0));
            if (out_valid === 1'b0) begin
                check("y_zero_when_idle", longint'(y), 0);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got y=%0d, required no output", y);
                end else begin
                    mon_exp = sb.pop_front();
                    check("y_order", longint'(y), longint'(mon_exp));
                end
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic send(input int v);
        valid = 1'b1;
        x     = IW'(v);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    // Three discarded samples followed by the kept one
    task automatic kept(input int v, input int exp_y, input bit stored);
        if (stored) begin
            sb.push_back(OW'(exp_y));
        end
        repeat (M - 1) send(0);
        send(v);
    endtask

    task automatic wait_drain(input string name);
        int budget;
        budget = 60;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check(name, longint'(sb.size()), 0);
    endtask

    initial begin
        int d0;
        int o0;
        clear     = 1'b1;
        valid     = 1'b0;
        x         = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", longint'(level), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_y", longint'(y), 0);
        check("rst_overflow", longint'(overflow), 0);
        check("rst_drop", longint'(drop), 0);
        clear = 1'b0;

        // Basic decimation and latency
        send(16);
        send(32);
        send(48);
        sb.push_back(OW'(4));
        send(64);
        check("lat_t0_out_valid", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        check("lat_t1_out_valid", longint'(out_valid), 1);
        @(posedge clk);
        #1;
        check("lat_t2_out_valid", longint'(out_valid), 0);
        check("lat_out_count", longint'(out_cnt), 1);
        wait_drain("drain_basic");

        // Rounding
        kept(24, 2, 1'b1);
        kept(-24, -1, 1'b1);
        kept(7, 0, 1'b1);
        wait_drain("drain_round");
        check("round_overflow", longint'(overflow), 0);

        // Out of range
        kept(4000, EXP_POS_BIG, 1'b1);
        wait_drain("drain_pos_big");
        check("big_overflow", longint'(overflow), 1);
        kept(-4000, EXP_NEG_BIG, 1'b1);
        wait_drain("drain_neg_big");

        // Full FIFO drops the fifth result
        out_ready = 1'b0;
        d0 = drop_cnt;
        kept(16, 1, 1'b1);
        kept(32, 2, 1'b1);
        kept(48, 3, 1'b1);
        kept(64, 4, 1'b1);
        kept(80, 5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("full_level", longint'(level), 4);
        check("full_drop_pulses", longint'(drop_cnt - d0), 1);
        out_ready = 1'b1;
        wait_drain("drain_full");
        check("full_drained_level", longint'(level), 0);

        // Write and pop on the same edge while full
        out_ready = 1'b0;
        kept(16, 1, 1'b1);
        kept(32, 2, 1'b1);
        kept(48, 3, 1'b1);
        kept(64, 4, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("wp_full_level", longint'(level), 4);
        d0 = drop_cnt;
        repeat (M - 1) send(0);
        sb.push_back(OW'(6));
        send(96);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("wp_level_stays", longint'(level), 4);
        repeat (2) @(posedge clk);
        #1;
        check("wp_no_drop", longint'(drop_cnt - d0), 0);
        out_ready = 1'b1;
        wait_drain("drain_wp");

        // Mid-stream clear; valid during clear must be ignored
        out_ready = 1'b0;
        kept(16, 1, 1'b1);
        kept(32, 2, 1'b1);
        kept(48, 3, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("pre_clr_level", longint'(level), 3);
        send(0);
        send(0);
        clear = 1'b1;
        valid = 1'b1;
        x     = IW'(64);
        sb.delete();
        @(posedge clk);
        #1;
        clear = 1'b0;
        valid = 1'b0;
        check("clr_level", longint'(level), 0);
        check("clr_out_valid", longint'(out_valid), 0);
        check("clr_overflow", longint'(overflow), 0);
        check("clr_y", longint'(y), 0);
        out_ready = 1'b1;
        o0 = out_cnt;
        send(16);
        send(32);
        send(48);
        sb.push_back(OW'(7));
        send(112);
        wait_drain("drain_clr");
        repeat (3) @(posedge clk);
        #1;
        check("clr_one_output", longint'(out_cnt - o0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
